// File: rtl/main_stream_pkg.sv
// Shared constants for the main_stream frame source: FSM encodings, defaults and parameter checks.
package main_stream_pkg;

  localparam int unsigned DEF_MEM_SIZE   = 4096;
  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_FRAME_LEN  = 16;
  localparam int unsigned STRB_W         = DEF_DATA_WIDTH / 8;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_FILL   = 2'd1;
  localparam logic [STATE_W-1:0] ST_PRIME  = 2'd2;
  localparam logic [STATE_W-1:0] ST_STREAM = 2'd3;

  function automatic bit params_ok(input int unsigned mem_size, input int unsigned addr_width,
                                   input int unsigned data_width, input int unsigned frame_len);
    return (mem_size == (32'(1) << addr_width)) && (frame_len >= 1) && (frame_len <= mem_size) &&
           (data_width > 0) && ((data_width % 8) == 0);
  endfunction

endpackage

// File: rtl/main_stream_if.sv
// Fill-side enable/ready plus AXI4-Stream master bundle of the frame source.
interface main_stream_if #(
  parameter int unsigned DATA_WIDTH = main_stream_pkg::DEF_DATA_WIDTH
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic                  s03_axis_enable;
  logic                  s03_axis_tready;
  logic                  m03_axis_tready;
  logic [DATA_WIDTH-1:0] m03_axis_tdata;
  logic [STRB_W-1:0]     m03_axis_tstrb;
  logic                  m03_axis_tvalid;
  logic                  m03_axis_tlast;

  modport master (
    input  s03_axis_enable, m03_axis_tready,
    output s03_axis_tready, m03_axis_tdata, m03_axis_tstrb, m03_axis_tvalid, m03_axis_tlast
  );

  modport slave (
    output s03_axis_enable, m03_axis_tready,
    input  s03_axis_tready, m03_axis_tdata, m03_axis_tstrb, m03_axis_tvalid, m03_axis_tlast
  );
endinterface

// File: rtl/main_stream_wrapper_ram.sv
// stream_frame_ram: simple dual-port frame store, one write port and one registered read port.
module stream_frame_ram #(
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register doubles as the stream data output register, so it is reset but the array is not.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/main_stream_wrapper.sv
// Frame source: fills a RAM with a running count, then replays one frame on an AXI4-Stream master.
module main_stream_wrapper
  import main_stream_pkg::*;
#(
  parameter int unsigned MEM_SIZE   = DEF_MEM_SIZE,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAME_LEN  = DEF_FRAME_LEN
) (
  input  logic         axis_aclk,
  input  logic         axis_areset,
  main_stream_if.master bus
);
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam bit SINGLE = (FRAME_LEN == 1);

  if (!params_ok(MEM_SIZE, ADDR_WIDTH, DATA_WIDTH, FRAME_LEN)) begin : g_bad_params
    $error("main_stream_wrapper: inconsistent MEM_SIZE/ADDR_WIDTH/DATA_WIDTH/FRAME_LEN");
  end

  logic [STATE_W-1:0]    state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt, raddr;
  logic [DATA_WIDTH-1:0] pattern, pattern_nxt, rdata;
  logic                  tvalid, tvalid_nxt, tlast, tlast_nxt, we, re;
  logic [SW-1:0]         tstrb, tstrb_nxt;

  stream_frame_ram #(
    .DEPTH(MEM_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk(axis_aclk), .rst(axis_areset),
    .we(we), .waddr(wr_ptr), .wdata(pattern),
    .re(re), .raddr(raddr), .rdata(rdata)
  );

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pattern <= '0;
      tvalid  <= 1'b0;
      tlast   <= 1'b0;
      tstrb   <= '0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      pattern <= pattern_nxt;
      tvalid  <= tvalid_nxt;
      tlast   <= tlast_nxt;
      tstrb   <= tstrb_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    pattern_nxt = pattern;
    tvalid_nxt  = tvalid;
    tlast_nxt   = tlast;
    tstrb_nxt   = tstrb;
    we          = 1'b0;
    re          = 1'b0;
    raddr       = '0;
    case (state)
      ST_IDLE: begin
        if (bus.s03_axis_enable) begin
          we          = 1'b1;
          pattern_nxt = pattern + DATA_WIDTH'(1);
          if (SINGLE) begin
            state_nxt = ST_PRIME;
          end else begin
            wr_ptr_nxt = ADDR_WIDTH'(1);
            state_nxt  = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (bus.s03_axis_enable) begin
          we          = 1'b1;
          pattern_nxt = pattern + DATA_WIDTH'(1);
          if (wr_ptr == LAST_IDX) state_nxt  = ST_PRIME;
          else                    wr_ptr_nxt = wr_ptr + ADDR_WIDTH'(1);
        end
      end
      ST_PRIME: begin
        re         = 1'b1;
        tvalid_nxt = 1'b1;
        tstrb_nxt  = '1;
        tlast_nxt  = SINGLE;
        rd_ptr_nxt = '0;
        state_nxt  = ST_STREAM;
      end
      ST_STREAM: begin
        // tvalid is always high here, so tready alone marks a handshake.
        if (bus.m03_axis_tready) begin
          if (tlast) begin
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
            tstrb_nxt  = '0;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            state_nxt  = ST_IDLE;
          end else begin
            re         = 1'b1;
            raddr      = rd_ptr + ADDR_WIDTH'(1);
            rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
            tlast_nxt  = ((rd_ptr + ADDR_WIDTH'(1)) == LAST_IDX);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.s03_axis_tready = ((state == ST_IDLE) || (state == ST_FILL)) && !axis_areset;
  assign bus.m03_axis_tdata  = rdata;
  assign bus.m03_axis_tstrb  = tstrb;
  assign bus.m03_axis_tvalid = tvalid;
  assign bus.m03_axis_tlast  = tlast;
endmodule

// File: tb/tb_main_stream_wrapper.sv
// Directed self-checking bench for main_stream_wrapper (default parameters, 16-word frames).
module tb_main_stream_wrapper;
  localparam int unsigned DW = 32;
  localparam int unsigned FL = 16;

  logic clk;
  logic areset;
  int   n_tests;
  int   n_fail;

  main_stream_if #(.DATA_WIDTH(DW)) bus ();

  main_stream_wrapper #(
    .MEM_SIZE(4096), .ADDR_WIDTH(12), .DATA_WIDTH(DW), .FRAME_LEN(FL)
  ) dut (
    .axis_aclk(clk),
    .axis_areset(areset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Runs until nhs handshakes complete; words must be base, base+1, ... with tlast on word FL-1.
  task automatic run_frame(input int base, input int nhs, input bit en_tog, input bit rdy_rnd,
                           output int lat, output int wr_beats);
    logic [15:0] rdy_pat;
    int cyc, hs, first_wr, first_valid;
    bit hshk;
    rdy_pat     = 16'b1011_0010_1110_0101;
    cyc         = 0;
    hs          = 0;
    first_wr    = -1;
    first_valid = -1;
    wr_beats    = 0;
    while (hs < nhs && cyc < 400) begin
      bus.s03_axis_enable = en_tog ? (cyc % 2 == 0) : 1'b1;
      bus.m03_axis_tready = rdy_rnd ? rdy_pat[cyc % 16] : 1'b1;
      if (bus.s03_axis_enable && bus.s03_axis_tready) begin
        wr_beats++;
        if (first_wr < 0) first_wr = cyc;
      end
      if (bus.m03_axis_tvalid) begin
        if (first_valid < 0) first_valid = cyc;
        check("tdata", 64'(bus.m03_axis_tdata), 64'(32'(base + hs)));
        check("tlast", 64'(bus.m03_axis_tlast), 64'(hs == FL - 1));
        check("tstrb_valid", 64'(bus.m03_axis_tstrb), 64'h0F);
        check("s_tready_busy", 64'(bus.s03_axis_tready), 64'd0);
      end else begin
        check("strb_last_idle", 64'({bus.m03_axis_tstrb, bus.m03_axis_tlast}), 64'd0);
      end
      hshk = bus.m03_axis_tvalid && bus.m03_axis_tready;
      @(negedge clk);
      cyc++;
      if (hshk) hs++;
    end
    check("handshake_count", 64'(hs), 64'(nhs));
    lat = first_valid - first_wr;
  endtask

  initial begin
    int lat, wr;
    n_tests = 0;
    n_fail  = 0;
    areset  = 1'b1;
    bus.s03_axis_enable = 1'b0;
    bus.m03_axis_tready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_tvalid", 64'(bus.m03_axis_tvalid), 64'd0);
    check("rst_tdata", 64'(bus.m03_axis_tdata), 64'd0);
    check("rst_tlast", 64'(bus.m03_axis_tlast), 64'd0);
    check("rst_tstrb", 64'(bus.m03_axis_tstrb), 64'd0);
    check("rst_s_tready", 64'(bus.s03_axis_tready), 64'd0);
    areset = 1'b0;
    @(negedge clk);
    check("idle_s_tready", 64'(bus.s03_axis_tready), 64'd1);

    // Frame 1: enable and tready held high.
    run_frame(0, FL, 1'b0, 1'b0, lat, wr);
    check("f1_latency", 64'(lat), 64'(FL + 1));
    check("f1_writes", 64'(wr), 64'(FL));
    check("turnaround_tvalid", 64'(bus.m03_axis_tvalid), 64'd0);
    check("turnaround_s_tready", 64'(bus.s03_axis_tready), 64'd1);

    // Frame 2: pattern continues from 16.
    run_frame(16, FL, 1'b0, 1'b0, lat, wr);
    check("f2_latency", 64'(lat), 64'(FL + 1));
    check("f2_writes", 64'(wr), 64'(FL));

    // Partial frame 3, reset after word 5 (data 32..37).
    run_frame(32, 6, 1'b0, 1'b0, lat, wr);
    check("mid_tvalid", 64'(bus.m03_axis_tvalid), 64'd1);
    areset = 1'b1;
    @(negedge clk);
    check("mid_rst_tvalid", 64'(bus.m03_axis_tvalid), 64'd0);
    check("mid_rst_tdata", 64'(bus.m03_axis_tdata), 64'd0);
    check("mid_rst_tlast", 64'(bus.m03_axis_tlast), 64'd0);
    check("mid_rst_tstrb", 64'(bus.m03_axis_tstrb), 64'd0);
    check("mid_rst_s_tready", 64'(bus.s03_axis_tready), 64'd0);
    areset = 1'b0;
    bus.s03_axis_enable = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", 64'(bus.s03_axis_tready), 64'd1);
    check("post_rst_tvalid", 64'(bus.m03_axis_tvalid), 64'd0);

    // Enable toggling during fill: pattern restarts at 0 after reset.
    run_frame(0, FL, 1'b1, 1'b0, lat, wr);
    check("tog_writes", 64'(wr), 64'(FL));

    // Irregular tready during stream.
    run_frame(16, FL, 1'b0, 1'b1, lat, wr);
    check("rnd_writes", 64'(wr), 64'(FL));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/main_stream_wrapper.md
Name: main_stream_wrapper

Overview:
Self-contained AXI4-Stream frame source. While enabled, it fills an internal RAM with a running counter pattern, one frame of FRAME_LEN words. It then replays that frame on an AXI4-Stream master port with full tvalid/tready handshaking and tlast.
It is the top-level data-path wrapper that ties the slave-side fill engine to the master-side stream engine. Single clock domain.

Parameters:
MEM_SIZE, 4096, RAM depth in words; must equal 2**ADDR_WIDTH.
ADDR_WIDTH, 12, RAM address width.
DATA_WIDTH, 32, stream word width; multiple of 8.
FRAME_LEN, 16, words per frame; range 1..MEM_SIZE.

Ports:
axis_aclk  in  1  sole clock; all logic on the rising edge.
axis_areset  in  1  synchronous, active-high reset.
s03_axis_enable  in  1  fill enable; a write beat occurs when enable and tready are both high.
s03_axis_tready  out  1  fill side ready; high in IDLE and FILL.
m03_axis_tready  in  1  downstream ready.
m03_axis_tdata  out  DATA_WIDTH  stream data.
m03_axis_tstrb  out  DATA_WIDTH/8  byte strobes.
m03_axis_tvalid  out  1  stream valid.
m03_axis_tlast  out  1  last word of frame.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (axis_areset=1 at an edge):
  - state=IDLE; wr_ptr, rd_ptr, beat count and pattern counter all = 0.
  - All outputs = 0, including s03_axis_tready.
  - Takes priority over every other event, including mid-fill and mid-stream; any partially filled or partially sent frame is discarded.
  - RAM contents are not cleared.
- s03_axis_tready = 1 in IDLE and FILL, 0 otherwise; combinational from state.
- FSM states: IDLE, FILL, PRIME, STREAM.
- IDLE:
  - On a write beat: mem[0] <= pattern, pattern++, wr_ptr <= 1, go to FILL.
  - If FRAME_LEN==1, go directly to PRIME instead.
- FILL:
  - Each write beat: mem[wr_ptr] <= pattern, pattern++, wr_ptr++.
  - Enable low pauses the fill with no write; state and pointers hold.
  - When the beat writing index FRAME_LEN-1 completes, go to PRIME.
- PRIME (one cycle):
  - Synchronous RAM read of address 0 into the output register.
  - Next edge: tvalid=1, tdata=mem[0], tlast=(FRAME_LEN==1), rd_ptr=0; go to STREAM.
- STREAM:
  - tvalid stays high; tdata, tlast and tstrb stay stable while m03_axis_tready=0.
  - Handshake (tvalid & tready) on a non-last word: load mem[rd_ptr+1], rd_ptr++, tlast = (rd_ptr+1 == FRAME_LEN-1). This sustains one word per cycle with no bubbles.
  - Handshake on the tlast word: tvalid, tlast and tstrb drop to 0 at that edge; wr_ptr and rd_ptr reset; go to IDLE.
- m03_axis_tstrb = all ones whenever tvalid=1, otherwise 0.
- Pattern counter:
  - DATA_WIDTH bits; wraps modulo 2**DATA_WIDTH.
  - Not cleared between frames, so consecutive frames continue the count (0..15, 16..31, ...).
- Latency:
  - First write beat at edge E0 gives first tvalid=1 after edge E0+FRAME_LEN+1, with no enable gaps.
  - Back-to-back frames with enable and tready held high: one IDLE cycle per frame turnaround.
- s03_axis_enable during PRIME and STREAM is ignored; no writes occur.
- Addresses use ADDR_WIDTH bits; pointers never exceed FRAME_LEN-1.

Decomposition:
- Package main_stream_pkg:
  - state enum {IDLE, FILL, PRIME, STREAM}.
  - Derived constant STRB_W = DATA_WIDTH/8.
  - Elaboration checks: MEM_SIZE==2**ADDR_WIDTH, FRAME_LEN<=MEM_SIZE, DATA_WIDTH%8==0.
- One sub-module: stream_frame_ram, a simple dual-port RAM with one write port, one synchronous-read port and a single clock.
- The FSM and output register live in the wrapper.

Test Plan:
- Reset release, then enable=1 and m03_axis_tready=1 continuously -> s03_axis_tready=1. The first frame outputs tdata 0..15 on 16 consecutive cycles, tstrb=4'hF, and tlast only with tdata=15. tvalid rises FRAME_LEN+1 edges after the first write beat.
- Enable toggled 1/0 each cycle during fill -> only 16 write beats are counted; the streamed data is still exactly 0..15, with no gaps or duplicates.
- m03_axis_tready toggled pseudo-randomly during stream -> tdata/tlast stay stable while stalled. Exactly 16 handshakes occur, values 0..15 in order, with no loss or repetition.
- Enable held high across two frames -> the second frame streams 16..31 with tlast on 31. There is one IDLE cycle between frames (tvalid=0).
- axis_areset asserted mid-stream (after word 5) -> next edge all outputs = 0 and state=IDLE. Re-enabling restarts the pattern at 0.
- With tvalid=0 (IDLE, FILL, PRIME) -> tstrb=0 and tlast=0. During PRIME and STREAM -> s03_axis_tready=0.
